// File: rtl/drs_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : drs_seq_ctrl_if
//  Description : Control/status bundle between the DRS sequencer and its
//                surroundings. Signal suffixes are from the sequencer's view:
//                _i are sequencer inputs, _o are sequencer outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface drs_seq_ctrl_if;
  logic        run_en_i;
  logic        trig_i;
  logic [7:0]  stop_delay_i;
  logic        fifo_progfull_i;
  logic        drs_read_done_i;

  logic [3:0]  drs_state_com_o;
  logic        drs_denable_o;
  logic        drs_dwrite_o;
  logic        busy_o;
  logic [31:0] event_cnt_o;
  logic [15:0] trig_lost_cnt_o;
  logic        read_tmo_err_o;

  // Sequencer side
  modport slave (
    input  run_en_i, trig_i, stop_delay_i, fifo_progfull_i, drs_read_done_i,
    output drs_state_com_o, drs_denable_o, drs_dwrite_o, busy_o,
           event_cnt_o, trig_lost_cnt_o, read_tmo_err_o
  );

  // Controlling side (system / bench)
  modport master (
    output run_en_i, trig_i, stop_delay_i, fifo_progfull_i, drs_read_done_i,
    input  drs_state_com_o, drs_denable_o, drs_dwrite_o, busy_o,
           event_cnt_o, trig_lost_cnt_o, read_tmo_err_o
  );
endinterface
`default_nettype wire

// File: rtl/drs_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : drs_seq_ctrl
//  Description : DRS domino sampling sequencer. Arms the sampling array,
//                accepts a trigger, freezes the cells after a programmable
//                stop delay, hands off to the readout engine, then waits a
//                dead time before re-arming. Counts events and lost triggers.
//  Revision    : 1.0  initial release
// ============================================================================
module drs_seq_ctrl #(
  parameter int unsigned MIN_ARM_CYC = 16,
  parameter int unsigned DEAD_CYC    = 4,
  parameter int unsigned READ_TMO    = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  drs_seq_ctrl_if.slave bus
);

  // State codes double as the command word sent to the readout engine
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARM     = 4'd1;
  localparam logic [3:0] S_SAMPLE  = 4'd2;
  localparam logic [3:0] S_STOPDLY = 4'd3;
  localparam logic [3:0] S_READ    = 4'd5;
  localparam logic [3:0] S_FINISH  = 4'd6;
  localparam logic [3:0] S_DEAD    = 4'd7;

  // Each timed state counts up from 0 to (N-1); N=0 behaves like N=1
  localparam int unsigned ARM_W  = (MIN_ARM_CYC < 2) ? 1 : $clog2(MIN_ARM_CYC);
  localparam int unsigned DEAD_W = (DEAD_CYC    < 2) ? 1 : $clog2(DEAD_CYC);
  localparam int unsigned TMO_W  = (READ_TMO    < 2) ? 1 : $clog2(READ_TMO);

  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'((MIN_ARM_CYC == 0) ? 0 : MIN_ARM_CYC - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYC == 0) ? 0 : DEAD_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((READ_TMO == 0) ? 0 : READ_TMO - 1);

  logic [3:0]        state_q,    state_d;
  logic [ARM_W-1:0]  arm_cnt_q,  arm_cnt_d;
  logic [7:0]        dly_cnt_q,  dly_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic              tmo_evt_q,  tmo_evt_d;
  logic              tmo_err_q,  tmo_err_d;
  logic [31:0]       evt_cnt_q,  evt_cnt_d;
  logic [15:0]       lost_cnt_q, lost_cnt_d;
  logic              dwrite_q,   dwrite_d;
  logic              denable_q,  denable_d;
  logic              busy_q,     busy_d;

  logic              w_can_arm;
  logic              w_lost_inc;

  assign w_can_arm = bus.run_en_i & ~bus.fifo_progfull_i;

  // Next-state, counter and trigger bookkeeping
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    dead_cnt_d = dead_cnt_q;
    tmo_evt_d  = tmo_evt_q;
    tmo_err_d  = tmo_err_q;
    evt_cnt_d  = evt_cnt_q;
    w_lost_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_can_arm) begin
          state_d   = S_ARM;
          arm_cnt_d = '0;
        end
      end
      S_ARM: begin
        if (!bus.run_en_i) begin
          state_d = S_IDLE;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // Losing the run enable wins over a coincident trigger
        if (!bus.run_en_i) begin
          state_d    = S_IDLE;
          w_lost_inc = bus.trig_i;
        end else if (bus.trig_i) begin
          if (bus.fifo_progfull_i) begin
            w_lost_inc = 1'b1;
          end else begin
            state_d   = S_STOPDLY;
            dly_cnt_d = bus.stop_delay_i;
            tmo_evt_d = 1'b0;
          end
        end
      end
      S_STOPDLY: begin
        if (dly_cnt_q == 8'd0) begin
          state_d   = S_READ;
          tmo_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q - 8'd1;
        end
      end
      S_READ: begin
        if (bus.drs_read_done_i) begin
          state_d = S_FINISH;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_FINISH;
          tmo_err_d = 1'b1;
          tmo_evt_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        // Wait for the readout engine to drop DONE after seeing FINISH
        if (!bus.drs_read_done_i) begin
          state_d    = S_DEAD;
          dead_cnt_d = '0;
          if (!tmo_evt_q) begin
            evt_cnt_d = evt_cnt_q + 32'd1;
          end
        end
      end
      S_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          state_d   = w_can_arm ? S_ARM : S_IDLE;
          arm_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any trigger seen outside SAMPLE is lost
    if ((state_q != S_SAMPLE) && bus.trig_i) begin
      w_lost_inc = 1'b1;
    end
  end

  // Saturating lost-trigger count
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (w_lost_inc && (lost_cnt_q != 16'hFFFF)) begin
      lost_cnt_d = lost_cnt_q + 16'd1;
    end
  end

  // Output decode from the next state so outputs line up with state_q
  always_comb begin
    dwrite_d  = (state_d == S_ARM) || (state_d == S_SAMPLE) || (state_d == S_STOPDLY);
    denable_d = (state_d != S_IDLE);
    busy_d    = !((state_d == S_SAMPLE) && !bus.fifo_progfull_i);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      arm_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      dead_cnt_q <= '0;
      tmo_evt_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      evt_cnt_q  <= '0;
      lost_cnt_q <= '0;
      dwrite_q   <= 1'b0;
      denable_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      tmo_evt_q  <= tmo_evt_d;
      tmo_err_q  <= tmo_err_d;
      evt_cnt_q  <= evt_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      dwrite_q   <= dwrite_d;
      denable_q  <= denable_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.drs_state_com_o = state_q;
  assign bus.drs_denable_o   = denable_q;
  assign bus.drs_dwrite_o    = dwrite_q;
  assign bus.busy_o          = busy_q;
  assign bus.event_cnt_o     = evt_cnt_q;
  assign bus.trig_lost_cnt_o = lost_cnt_q;
  assign bus.read_tmo_err_o  = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_drs_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drs_seq_ctrl
//  Description : Self-checking bench for drs_seq_ctrl: scripted vector table,
//                hand sequences for timeout and mid-event reset, and random
//                stimulus against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_drs_seq_ctrl;

  localparam int P_ARM  = 16;
  localparam int P_DEAD = 4;
  localparam int P_TMO  = 100;

  logic clk;
  logic rst_n;

  drs_seq_ctrl_if bus ();

  drs_seq_ctrl #(
    .MIN_ARM_CYC (P_ARM),
    .DEAD_CYC    (P_DEAD),
    .READ_TMO    (P_TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ARM, M_SAMPLE, M_STOPDLY, M_READ, M_FINISH, M_DEAD} mstate_e;

  mstate_e     m_st;
  int          m_left;      // cycles remaining in the current timed phase
  bit          m_tmo_evt;
  int unsigned m_evt;
  int          m_lost;
  bit          m_err;
  bit          m_busy;

  function automatic logic [3:0] code_of(input mstate_e s);
    case (s)
      M_IDLE:    return 4'd0;
      M_ARM:     return 4'd1;
      M_SAMPLE:  return 4'd2;
      M_STOPDLY: return 4'd3;
      M_READ:    return 4'd5;
      M_FINISH:  return 4'd6;
      default:   return 4'd7;
    endcase
  endfunction

  function automatic int atleast1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_left = 0; m_tmo_evt = 0;
    m_evt = 0; m_lost = 0; m_err = 0; m_busy = 1;
  endtask

  task automatic model_step();
    bit run, trg, full, done, go_arm, lost;
    mstate_e nx;
    run = bus.run_en_i; trg = bus.trig_i; full = bus.fifo_progfull_i; done = bus.drs_read_done_i;
    go_arm = run && !full;
    lost = trg && (m_st != M_SAMPLE);
    nx = m_st;
    case (m_st)
      M_IDLE: if (go_arm) begin nx = M_ARM; m_left = atleast1(P_ARM); end
      M_ARM: begin
        if (!run) nx = M_IDLE;
        else begin m_left--; if (m_left == 0) nx = M_SAMPLE; end
      end
      M_SAMPLE: begin
        if (!run) begin nx = M_IDLE; lost = trg; end
        else if (trg && full) lost = 1;
        else if (trg) begin nx = M_STOPDLY; m_left = int'(bus.stop_delay_i) + 1; m_tmo_evt = 0; end
      end
      M_STOPDLY: begin
        m_left--;
        if (m_left == 0) begin nx = M_READ; m_left = atleast1(P_TMO); end
      end
      M_READ: begin
        if (done) nx = M_FINISH;
        else begin
          m_left--;
          if (m_left == 0) begin nx = M_FINISH; m_err = 1; m_tmo_evt = 1; end
        end
      end
      M_FINISH: if (!done) begin
        nx = M_DEAD; m_left = atleast1(P_DEAD);
        if (!m_tmo_evt) m_evt = m_evt + 1;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          nx = go_arm ? M_ARM : M_IDLE;
          m_left = atleast1(P_ARM);
        end
      end
    endcase
    if (lost && m_lost < 65535) m_lost++;
    m_st = nx;
    m_busy = !(nx == M_SAMPLE && !full);
  endtask

  task automatic check_model();
    check("mdl_com",     {28'd0, bus.drs_state_com_o}, {28'd0, code_of(m_st)});
    check("mdl_dwrite",  {31'd0, bus.drs_dwrite_o}, {31'd0, (m_st inside {M_ARM, M_SAMPLE, M_STOPDLY})});
    check("mdl_denable", {31'd0, bus.drs_denable_o}, {31'd0, (m_st != M_IDLE)});
    check("mdl_busy",    {31'd0, bus.busy_o}, {31'd0, m_busy});
    check("mdl_evt",     bus.event_cnt_o, m_evt);
    check("mdl_lost",    {16'd0, bus.trig_lost_cnt_o}, m_lost);
    check("mdl_err",     {31'd0, bus.read_tmo_err_o}, {31'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    check_model();
  endtask

  task automatic drive(input bit run, input bit trg, input bit full, input bit done, input logic [7:0] sd);
    bus.run_en_i = run; bus.trig_i = trg; bus.fifo_progfull_i = full;
    bus.drs_read_done_i = done; bus.stop_delay_i = sd;
  endtask

  task automatic wait_com(input logic [3:0] c, input int budget);
    int n;
    n = 0;
    while (bus.drs_state_com_o !== c && n < budget) begin tick(); n++; end
    check("wait_com", {28'd0, bus.drs_state_com_o}, {28'd0, c});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit run, trg, full, done; logic [7:0] sd; int cyc;
    logic [3:0] com; bit dwrite, denable, busy; int lost; int evt;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit run, input bit trg, input bit full, input bit done, input int sd,
                      input int cyc, input int com, input bit dw, input bit de, input bit bz,
                      input int lost, input int evt);
    vec_t v;
    v.run = run; v.trg = trg; v.full = full; v.done = done; v.sd = 8'(sd); v.cyc = cyc;
    v.com = 4'(com); v.dwrite = dw; v.denable = de; v.busy = bz; v.lost = lost; v.evt = evt;
    tbl.push_back(v);
  endtask

  int saved_evt;

  initial begin
    //   run trg full done sd cyc com dw de bz lost evt
    addv(1, 0, 0, 0, 0,  1, 1, 1, 1, 1, 0, 0);   // IDLE -> ARM
    addv(1, 0, 0, 0, 0, 15, 1, 1, 1, 1, 0, 0);   // ARM lasts 16 cycles
    addv(1, 0, 0, 0, 0,  1, 2, 1, 1, 0, 0, 0);   // SAMPLE, ready
    addv(1, 1, 0, 0, 3,  1, 3, 1, 1, 1, 0, 0);   // trigger accepted, delay 3
    addv(1, 0, 0, 0, 0,  3, 3, 1, 1, 1, 0, 0);   // still counting down
    addv(1, 0, 0, 0, 0,  1, 5, 0, 1, 1, 0, 0);   // DWRITE falls 4 after TRIG
    addv(1, 0, 0, 0, 0,  9, 5, 0, 1, 1, 0, 0);
    addv(1, 0, 0, 1, 0,  1, 6, 0, 1, 1, 0, 0);   // DONE 10 cycles into READ
    addv(1, 0, 0, 1, 0,  1, 6, 0, 1, 1, 0, 0);   // FINISH holds while DONE
    addv(1, 0, 0, 0, 0,  1, 7, 0, 1, 1, 0, 1);   // DEAD, event counted
    addv(1, 0, 0, 0, 0,  3, 7, 0, 1, 1, 0, 1);
    addv(1, 0, 0, 0, 0,  1, 1, 1, 1, 1, 0, 1);   // re-arm after dead time
    addv(1, 1, 0, 0, 0,  1, 1, 1, 1, 1, 1, 1);   // trig in ARM lost
    addv(1, 0, 0, 0, 0,  1, 1, 1, 1, 1, 1, 1);
    addv(1, 1, 0, 0, 0,  1, 1, 1, 1, 1, 2, 1);   // second trig in ARM lost
    addv(1, 0, 0, 0, 0, 12, 1, 1, 1, 1, 2, 1);
    addv(1, 0, 0, 0, 0,  1, 2, 1, 1, 0, 2, 1);
    addv(1, 1, 0, 0, 0,  1, 3, 1, 1, 1, 2, 1);   // delay 0
    addv(1, 0, 0, 0, 0,  1, 5, 0, 1, 1, 2, 1);   // READ 1 cycle after accept
    addv(1, 1, 0, 0, 0,  1, 5, 0, 1, 1, 3, 1);   // trig in READ lost
    addv(1, 0, 0, 1, 0,  1, 6, 0, 1, 1, 3, 1);
    addv(1, 0, 0, 0, 0,  1, 7, 0, 1, 1, 3, 2);   // event completes
    addv(1, 0, 0, 0, 0,  3, 7, 0, 1, 1, 3, 2);
    addv(1, 0, 0, 0, 0,  1, 1, 1, 1, 1, 3, 2);
    addv(1, 0, 0, 0, 0, 15, 1, 1, 1, 1, 3, 2);
    addv(1, 0, 0, 0, 0,  1, 2, 1, 1, 0, 3, 2);
    addv(1, 1, 1, 0, 0,  1, 2, 1, 1, 1, 4, 2);   // back-pressure rejects
    addv(1, 0, 1, 0, 0,  1, 2, 1, 1, 1, 4, 2);
    addv(1, 1, 1, 0, 0,  1, 2, 1, 1, 1, 5, 2);
    addv(1, 0, 1, 0, 0,  1, 2, 1, 1, 1, 5, 2);
    addv(1, 1, 1, 0, 0,  1, 2, 1, 1, 1, 6, 2);
    addv(1, 0, 0, 0, 0,  1, 2, 1, 1, 0, 6, 2);   // FIFO drains, ready again
    addv(0, 1, 0, 0, 0,  1, 0, 0, 0, 1, 7, 2);   // RUN_EN drop beats TRIG
    addv(0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 7, 2);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'd0);
    model_reset();
    repeat (3) tick();
    check("rst_com",  {28'd0, bus.drs_state_com_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd1);
    check("rst_dw",   {31'd0, bus.drs_dwrite_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Scripted vectors
    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].trg, tbl[i].full, tbl[i].done, tbl[i].sd);
      repeat (tbl[i].cyc) tick();
      check($sformatf("v%0d_com", i),  {28'd0, bus.drs_state_com_o}, {28'd0, tbl[i].com});
      check($sformatf("v%0d_dw", i),   {31'd0, bus.drs_dwrite_o}, {31'd0, tbl[i].dwrite});
      check($sformatf("v%0d_de", i),   {31'd0, bus.drs_denable_o}, {31'd0, tbl[i].denable});
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy_o}, {31'd0, tbl[i].busy});
      check($sformatf("v%0d_lost", i), {16'd0, bus.trig_lost_cnt_o}, tbl[i].lost);
      check($sformatf("v%0d_evt", i),  bus.event_cnt_o, tbl[i].evt);
    end

    // Readout timeout: DONE never comes
    drive(1, 0, 0, 0, 8'd0);
    wait_com(4'd2, 40);
    saved_evt = int'(bus.event_cnt_o);
    drive(1, 1, 0, 0, 8'd0);
    tick();
    drive(1, 0, 0, 0, 8'd0);
    tick();
    check("tmo_read", {28'd0, bus.drs_state_com_o}, 32'd5);
    repeat (P_TMO - 1) tick();
    check("tmo_still_read", {28'd0, bus.drs_state_com_o}, 32'd5);
    check("tmo_err_pre", {31'd0, bus.read_tmo_err_o}, 32'd0);
    tick();
    check("tmo_finish", {28'd0, bus.drs_state_com_o}, 32'd6);
    check("tmo_err", {31'd0, bus.read_tmo_err_o}, 32'd1);
    tick();
    check("tmo_dead", {28'd0, bus.drs_state_com_o}, 32'd7);
    check("tmo_evt_same", bus.event_cnt_o, saved_evt);

    // Reset in the middle of READ
    wait_com(4'd2, 60);
    drive(1, 1, 0, 0, 8'd5);
    tick();
    drive(1, 0, 0, 0, 8'd0);
    wait_com(4'd5, 20);
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("ar_com",  {28'd0, bus.drs_state_com_o}, 32'd0);
    check("ar_dw",   {31'd0, bus.drs_dwrite_o}, 32'd0);
    check("ar_de",   {31'd0, bus.drs_denable_o}, 32'd0);
    check("ar_busy", {31'd0, bus.busy_o}, 32'd1);
    check("ar_evt",  bus.event_cnt_o, 32'd0);
    check("ar_lost", {16'd0, bus.trig_lost_cnt_o}, 32'd0);
    check("ar_err",  {31'd0, bus.read_tmo_err_o}, 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_rearm", {28'd0, bus.drs_state_com_o}, 32'd1);
    check("ar_rearm_dw", {31'd0, bus.drs_dwrite_o}, 32'd1);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            8'($urandom_range(0, 7)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
